// File: rtl/cle_result_checker.sv
// cle_result_checker - raster-pass label scoreboard comparing a labeling engine's SRAM to a golden map.
// Optional CHK_FAIL_LOG_EN drives the registered fail_valid/fail_addr/fail_code log ports.
module cle_result_checker #(
  parameter int IMG_W   = 32,
  parameter int IMG_H   = 32,
  parameter int ADDR_W  = 10,
  parameter int LBL_W   = 8,
  parameter int MAX_OBJ = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] dut_a,
  input  logic [LBL_W-1:0]  dut_q,
  output logic [ADDR_W-1:0] gold_a,
  input  logic [LBL_W-1:0]  gold_q,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W:0]   err_cnt,
  output logic              fail_valid,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [1:0]        fail_code
);

  localparam int NPIX = IMG_W * IMG_H;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);

  typedef enum logic [2:0] {S_IDLE, S_PRIME, S_SCAN, S_DRAIN, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W:0]     err_q, err_d;
  logic                pass_q, pass_d;
  logic [MAX_OBJ-1:0]  map_vld_q, map_vld_d;
  logic [LBL_W-1:0]    map_lbl_q [MAX_OBJ];
  logic [LBL_W-1:0]    map_lbl_d [MAX_OBJ];

  logic                in_range, hit_vld, lbl_taken, pix_fail, claim, cmp_en;
  logic [LBL_W-1:0]    hit_lbl;

  // Classify the pixel whose data is arriving this cycle against the object map.
  always_comb begin
    in_range  = 1'b0;
    hit_vld   = 1'b0;
    hit_lbl   = '0;
    lbl_taken = 1'b0;
    for (int i = 0; i < MAX_OBJ; i++) begin
      if (gold_q == LBL_W'(i + 1)) begin
        in_range = 1'b1;
        hit_vld  = map_vld_q[i];
        hit_lbl  = map_lbl_q[i];
      end
      if (map_vld_q[i] && (map_lbl_q[i] == dut_q)) lbl_taken = 1'b1;
    end
    pix_fail = 1'b0;
    claim    = 1'b0;
    if (gold_q == '0)                        pix_fail = (dut_q != '0);
    else if (!in_range)                      pix_fail = 1'b1;
    else if (hit_vld)                        pix_fail = (dut_q != hit_lbl);
    else if ((dut_q == '0) || lbl_taken)     pix_fail = 1'b1;
    else                                     claim    = 1'b1;
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    err_d     = err_q;
    pass_d    = pass_q;
    map_vld_d = map_vld_q;
    map_lbl_d = map_lbl_q;
    cmp_en    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_PRIME;
          addr_d    = '0;
          err_d     = '0;
          pass_d    = 1'b0;
          map_vld_d = '0;
        end
      end
      S_PRIME: begin
        addr_d  = addr_q + 1'b1;
        state_d = S_SCAN;
      end
      S_SCAN: begin
        cmp_en = 1'b1;
        if (addr_q == LAST_ADDR) state_d = S_DRAIN;
        else                     addr_d  = addr_q + 1'b1;
      end
      S_DRAIN: begin
        cmp_en  = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        addr_d  = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (cmp_en && pix_fail && (err_q != '1)) err_d = err_q + 1'b1;
    if (cmp_en && claim) begin
      for (int i = 0; i < MAX_OBJ; i++) begin
        if (gold_q == LBL_W'(i + 1)) begin
          map_vld_d[i] = 1'b1;
          map_lbl_d[i] = dut_q;
        end
      end
    end
    if (state_q == S_DRAIN) pass_d = (err_d == '0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      err_q     <= '0;
      pass_q    <= 1'b0;
      map_vld_q <= '0;
      for (int i = 0; i < MAX_OBJ; i++) map_lbl_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      err_q     <= err_d;
      pass_q    <= pass_d;
      map_vld_q <= map_vld_d;
      for (int i = 0; i < MAX_OBJ; i++) map_lbl_q[i] <= map_lbl_d[i];
    end
  end

  assign dut_a   = addr_q;
  assign gold_a  = addr_q;
  assign busy    = (state_q == S_PRIME) || (state_q == S_SCAN) || (state_q == S_DRAIN);
  assign done    = (state_q == S_DONE);
  assign pass    = pass_q;
  assign err_cnt = err_q;

`ifdef CHK_FAIL_LOG_EN
  localparam logic [1:0] FC_BG        = 2'd0;
  localparam logic [1:0] FC_MISMATCH  = 2'd1;
  localparam logic [1:0] FC_BAD_FIRST = 2'd2;
  localparam logic [1:0] FC_RANGE     = 2'd3;

  logic [ADDR_W-1:0] pix_q;
  logic [1:0]        pix_code;
  logic              fv_q;
  logic [ADDR_W-1:0] fa_q;
  logic [1:0]        fc_q;

  always_comb begin
    pix_code = FC_BAD_FIRST;
    if (gold_q == '0)   pix_code = FC_BG;
    else if (!in_range) pix_code = FC_RANGE;
    else if (hit_vld)   pix_code = FC_MISMATCH;
  end

  // pix_q trails addr_q by one cycle, matching the memory read latency.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pix_q <= '0;
      fv_q  <= 1'b0;
      fa_q  <= '0;
      fc_q  <= '0;
    end else begin
      pix_q <= addr_q;
      fv_q  <= cmp_en && pix_fail;
      if (cmp_en && pix_fail) begin
        fa_q <= pix_q;
        fc_q <= pix_code;
      end
    end
  end

  assign fail_valid = fv_q;
  assign fail_addr  = fa_q;
  assign fail_code  = fc_q;
`else
  assign fail_valid = 1'b0;
  assign fail_addr  = '0;
  assign fail_code  = '0;
`endif

endmodule

// File: tb/tb_cle_result_checker.sv
// tb/tb_cle_result_checker.sv - randomized and directed bench for cle_result_checker against a raster-rule model.
module tb_cle_result_checker;
  localparam int IMG_W = 32, IMG_H = 32, ADDR_W = 10, LBL_W = 8, MAX_OBJ = 5;
  localparam int N = IMG_W * IMG_H;

  logic clk = 1'b0;
  logic rst_n, start;
  logic [ADDR_W-1:0] dut_a, gold_a, fail_addr;
  logic [LBL_W-1:0]  dut_q, gold_q;
  logic busy, done, pass, fail_valid;
  logic [ADDR_W:0] err_cnt;
  logic [1:0] fail_code;

  logic [7:0] gmem [N];
  logic [7:0] dmem [N];
  bit exp_fail [N];
  int exp_code [N];
  int exp_cum  [N];
  int last_fa, last_fc;

  int errors = 0, checks = 0;
  bit mon_on = 1'b0;
  int mon_k = 0;
  int done_k = -1;

  cle_result_checker #(.IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W), .LBL_W(LBL_W), .MAX_OBJ(MAX_OBJ)) dut (
    .clk(clk), .reset(rst_n), .start(start),
    .dut_a(dut_a), .dut_q(dut_q), .gold_a(gold_a), .gold_q(gold_q),
    .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
    .fail_valid(fail_valid), .fail_addr(fail_addr), .fail_code(fail_code)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    dut_q  <= dmem[dut_a];
    gold_q <= gmem[gold_a];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (cycle %0d): got %0d expected %0d", name, mon_k, act, exp);
    end
  endtask

  // Reference: walk the image in raster order applying the object/label rules directly.
  task automatic compute_model();
    bit vld [1:MAX_OBJ];
    int lbl [1:MAX_OBJ];
    int cnt = 0;
    last_fa = 0;
    last_fc = 0;
    for (int o = 1; o <= MAX_OBJ; o++) begin vld[o] = 0; lbl[o] = 0; end
    for (int p = 0; p < N; p++) begin
      int g, d, c;
      bit f, taken;
      g = gmem[p]; d = dmem[p]; f = 0; c = 0;
      if (g == 0) begin
        f = (d != 0); c = 0;
      end else if (g > MAX_OBJ) begin
        f = 1; c = 3;
      end else if (vld[g]) begin
        f = (d != lbl[g]); c = 1;
      end else begin
        taken = 0;
        for (int o = 1; o <= MAX_OBJ; o++) if (vld[o] && lbl[o] == d) taken = 1;
        if (d == 0 || taken) begin
          f = 1; c = 2;
        end else begin
          vld[g] = 1; lbl[g] = d;
        end
      end
      if (f) begin
        if (cnt < (1 << (ADDR_W + 1)) - 1) cnt++;
        last_fa = p; last_fc = c;
      end
      exp_fail[p] = f;
      exp_code[p] = c;
      exp_cum[p]  = cnt;
    end
  endtask

  // k = number of rising edges since the edge that sampled start.
  always @(negedge clk) begin
    if (mon_on) begin
      int k;
      k = mon_k;
      chk("busy", busy, k <= N);
      chk("done", done, k == N + 1);
      if (done && done_k < 0) done_k = k;
      chk("err_cnt", err_cnt, (k >= 2) ? exp_cum[k-2] : 0);
`ifdef CHK_FAIL_LOG_EN
      chk("fail_valid", fail_valid, (k >= 2) ? exp_fail[k-2] : 0);
      if (k >= 2 && exp_fail[k-2]) begin
        chk("fail_addr", fail_addr, k - 2);
        chk("fail_code", fail_code, exp_code[k-2]);
      end
`else
      chk("fail_valid_tied", fail_valid, 0);
      chk("fail_log_tied", {fail_addr, fail_code}, 0);
`endif
    end
  end

  task automatic clear_mems();
    for (int p = 0; p < N; p++) begin gmem[p] = 8'h00; dmem[p] = 8'h00; end
  endtask

  task automatic fill_random();
    int lab [1:MAX_OBJ];
    for (int o = 1; o <= MAX_OBJ; o++) lab[o] = $urandom_range(1, 255);
    if ($urandom_range(0, 3) == 0) lab[2] = lab[1];
    for (int p = 0; p < N; p++) begin
      int r, g, d;
      r = $urandom_range(0, 99);
      g = (r < 55) ? 0 : (r < 97) ? 1 + (r % MAX_OBJ) : MAX_OBJ + 1;
      if (g == 0)            d = ($urandom_range(0, 99) < 2) ? $urandom_range(1, 255) : 0;
      else if (g <= MAX_OBJ) d = lab[g];
      else                   d = $urandom_range(0, 255);
      if (g >= 1 && g <= MAX_OBJ && $urandom_range(0, 99) < 3) d = $urandom_range(0, 255);
      gmem[p] = 8'(g);
      dmem[p] = 8'(d);
    end
  endtask

  task automatic run_scan(input int abort_k, input int poke_k);
    compute_model();
    done_k = -1;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    mon_k = 0;
    mon_on = 1'b1;
    for (int k = 1; k <= N + 1; k++) begin
      @(posedge clk);
      mon_k = k;
      if (k == abort_k) begin
        mon_on = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_err", err_cnt, 0);
        chk("abort_pass", pass, 0);
        chk("abort_addr", dut_a, 0);
        chk("abort_fail_valid", fail_valid, 0);
        repeat (3) begin
          @(posedge clk);
          #1 chk("abort_no_done", done, 0);
        end
        @(negedge clk) rst_n = 1'b1;
        return;
      end
      if (k == poke_k || k == N + 1) #1 start = 1'b1;
      else if (k == poke_k + 1)      #1 start = 1'b0;
    end
    @(posedge clk);
    #1 start = 1'b0;
    mon_on = 1'b0;
    chk("latency_cycles", done_k + 2, 1027);
    chk("idle_after_done", busy, 0);
    chk("done_pulse_width", done, 0);
    chk("final_err", err_cnt, exp_cum[N-1]);
    chk("final_pass", pass, exp_cum[N-1] == 0);
`ifdef CHK_FAIL_LOG_EN
    if (exp_cum[N-1] != 0) begin
      chk("last_fail_addr", fail_addr, last_fa);
      chk("last_fail_code", fail_code, last_fc);
    end
`endif
    @(posedge clk);
    #1 chk("start_in_done_ignored", busy, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    clear_mems();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_err", err_cnt, 0);
    chk("rst_addr", {dut_a, gold_a}, 0);
    chk("rst_fail", {fail_valid, fail_addr, fail_code}, 0);
    @(negedge clk) rst_n = 1'b1;

    run_scan(-1, -1);
    chk("t1_pass", pass, 1);
    chk("t1_err", err_cnt, 0);

    for (int p = 5; p <= 9; p++) begin gmem[p] = 8'd1; dmem[p] = 8'h2A; end
    run_scan(-1, 400);
    chk("t2_pass", pass, 1);
    dmem[7] = 8'h2B;
    run_scan(-1, -1);
    chk("t2_err", err_cnt, 1);
    chk("t2_pass_low", pass, 0);
`ifdef CHK_FAIL_LOG_EN
    chk("t2_fail_addr", fail_addr, 7);
    chk("t2_fail_code", fail_code, 1);
`endif

    clear_mems();
    for (int p = 10; p <= 14; p++) begin gmem[p] = 8'd1; dmem[p] = 8'h11; end
    for (int p = 20; p <= 26; p++) begin gmem[p] = 8'd2; dmem[p] = 8'h11; end
    run_scan(-1, -1);
    chk("t3_err", err_cnt, 7);
`ifdef CHK_FAIL_LOG_EN
    chk("t3_fail_code", fail_code, 2);
`endif

    clear_mems();
    dmem[1023] = 8'h03;
    run_scan(-1, -1);
    chk("t4_err", err_cnt, 1);
`ifdef CHK_FAIL_LOG_EN
    chk("t4_fail_addr", fail_addr, 1023);
    chk("t4_fail_code", fail_code, 0);
`endif

    clear_mems();
    gmem[0] = 8'd6;
    run_scan(-1, -1);
    chk("t5_err", err_cnt, 1);
`ifdef CHK_FAIL_LOG_EN
    chk("t5_fail_code", fail_code, 3);
`endif
    for (int p = 0; p < N; p++) begin gmem[p] = 8'h00; dmem[p] = 8'hFF; end
    run_scan(-1, -1);
    chk("t5_err_all", err_cnt, 1024);

    fill_random();
    run_scan(500, -1);
    run_scan(-1, -1);

    for (int s = 0; s < 4; s++) begin
      fill_random();
      run_scan(-1, $urandom_range(10, 1000));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
